aes_encipher_multilane: RTL and testbench
=========================================

# aes_encipher_multilane

Parametrised AES encipher round engine, successor to the single-lane encipher block in the AES core. It takes one 128-bit block and applies the initial, main and final rounds for AES-128 or AES-256. It substitutes `SBOX_WORDS` 32-bit words per cycle through external S-box lanes, trading S-box area for latency. It adds a start/done handshake, per-operation key-length latching and synchronous abort. It sits between the key memory (driven by `round`) and the shared S-box bank.

## Interface
- `SBOX_WORDS`, default 1: S-box words substituted per cycle; legal values 1, 2, 4. Any other value is an elaboration error.
- `clk`  in  1  clock; all registers rise-edge triggered.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin encipher; accepted only when `ready`=1.
- `abort`  in  1  cancel the current operation.
- `keylen`  in  1  0 = AES-128 (NR=10), 1 = AES-256 (NR=14); sampled on the start-accept edge.
- `block`  in  128  plaintext; sampled on the start-accept edge.
- `round`  out  4  index of the round key required this cycle.
- `round_key`  in  128  round key for `round`; used combinationally.
- `sboxw`  out  32*SBOX_WORDS  S-box lane inputs; lane 0 occupies the MSBs.
- `new_sboxw`  in  32*SBOX_WORDS  S-box lane outputs, combinational return.
- `new_block`  out  128  state register {w0,w1,w2,w3}, w0 = [127:96].
- `ready`  out  1  idle, able to accept `start`.
- `done`  out  1  one-cycle pulse when a ciphertext is valid on `new_block`.

## Operation
- S = 4/SBOX_WORDS, the number of SBOX cycles per round. nr_reg holds the NR value latched at start.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE
  - `start`=1 and `abort`=0 → state ← `block`, nr_reg ← NR(`keylen`), round_ctr ← 0, ready ← 0, go to INIT.
- INIT
  - `round`=0; state ← state ^ `round_key`; round_ctr ← 1; sword_ctr ← 0; go to SBOX.
- SBOX
  - Lane j presents state word sword_ctr·SBOX_WORDS + j on `sboxw`.
  - That word ← the matching lane of `new_sboxw`.
  - sword_ctr increments modulo S. When sword_ctr = S−1, go to MAIN.
- MAIN
  - round_ctr < nr_reg: state ← MixColumns(ShiftRows(state)) ^ `round_key`; round_ctr++; go to SBOX.
  - Otherwise (final round): state ← ShiftRows(state) ^ `round_key`; ready ← 1; done ← 1; go to IDLE.
- `sboxw` = 0 outside SBOX cycles.
- `round` = round_ctr in every state.
- Arithmetic is GF(2^8), reduction polynomial 0x11b (xtime: shift left 1, XOR 0x1b if the MSB was set).

Boundary conditions:
- `start` while `ready`=0: ignored.
- `keylen` and `block` changes after start acceptance: no effect.
- `abort` in INIT, SBOX or MAIN: next edge → IDLE, ready=1, done=0, state cleared to 0, counters to 0.
- `abort` in IDLE: no effect. With simultaneous `start`, abort wins and start is dropped.
- `abort` in the final MAIN cycle: abort wins; no `done`.
- `reset` at any time: all registers take their reset values on the next edge.
- `new_block` holds the ciphertext until the next accepted `start` overwrites it.

## Timing
- Reset values:
  - `round`=0, `sboxw`=0, `new_block`=0
  - `ready`=1, `done`=0
  - FSM=IDLE, counters 0, nr_reg=10
- Latency: `done` is high, and `ready` returns to 1, exactly 1 + NR·(S+1) edges after the start-accept edge.
  - AES-128: 51 (SW=1), 31 (SW=2), 21 (SW=4).
  - AES-256: 71 / 43 / 29.
- `done` is high for exactly one cycle. In that same cycle `ready`=1, so `start` may be accepted back-to-back.
- `round_key` and `new_sboxw` must settle within the cycle. There is no registered path from them except into the state register.

## Structure
- Shared package `aes_pkg` holds:
  - FSM state typedef
  - `AES_128_BIT_KEY` / `AES_256_BIT_KEY` constants
  - `AES128_ROUNDS` = 10, `AES256_ROUNDS` = 14
  - functions gm2, gm3, mixw, mixcolumns, shiftrows, addroundkey
- One sub-module, `aes_enc_round_datapath`: combinational; produces the init, main and final next-state values from state and `round_key`.
- FSM, counters and lane muxing stay in the top module.

## Test plan
- The bench uses a combinational S-box model on every lane and a reference key-expansion model indexed by `round`.
- AES-128, SW=1: key 000102…0f, pt 00112233445566778899aabbccddeeff → `done` 51 edges after start, `new_block`=69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256, SW=4: key 000102…1f, same pt → `done` at 29 edges, `new_block`=8ea2b7ca516745bfeafc49904b496089.
- AES-128, SW=2: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → `done` at 31 edges, `new_block`=3925841d02dc09fbdc118597196a0b32. During the run, the `round` sequence is 0,1..10, and each MAIN cycle sees the correct round value.
- `keylen` toggled and `block` changed 3 cycles after start, plus a second `start` pulsed mid-run → first result unchanged, second start ignored. A back-to-back start in the `done` cycle is accepted and yields the correct second ciphertext.
- `abort` at edge 20 of an AES-256 run → next cycle `ready`=1, `new_block`=0, no `done` pulse. Abort + start together in IDLE → stays IDLE.
- `reset` asserted mid-SBOX → all outputs at reset values on the next edge. A following start produces a correct result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES encipher definitions: FSM states, key-length encodings and
// the GF(2^8) round helper functions used by the round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SBOX,
    MAIN
  } aes_enc_state_e;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] op);
    return gm2(op) ^ op;
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
            b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] data);
    return {mixw(data[127:96]), mixw(data[95:64]), mixw(data[63:32]), mixw(data[31:0])};
  endfunction

  // Columns are 32-bit words, row 0 in the MSB byte of each word.
  function automatic logic [127:0] shiftrows(input logic [127:0] data);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = data;
    return {{w0[31:24], w1[23:16], w2[15:8], w3[7:0]},
            {w1[31:24], w2[23:16], w3[15:8], w0[7:0]},
            {w2[31:24], w3[23:16], w0[15:8], w1[7:0]},
            {w3[31:24], w0[23:16], w1[15:8], w2[7:0]}};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] data,
                                               input logic [127:0] rkey);
    return data ^ rkey;
  endfunction

endpackage

// File: rtl/aes_enc_round_datapath.sv
// Combinational AES encipher round logic: next-state candidates for the
// initial key addition, a full main round and the final (no MixColumns) round.
module aes_enc_round_datapath
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] init_block,
  output logic [127:0] main_block,
  output logic [127:0] final_block
);

  logic [127:0] shifted;

  assign shifted     = shiftrows(state);
  assign init_block  = addroundkey(state, round_key);
  assign main_block  = addroundkey(mixcolumns(shifted), round_key);
  assign final_block = addroundkey(shifted, round_key);

endmodule

// File: rtl/aes_encipher_multilane.sv
// AES-128/256 encipher round engine substituting SBOX_WORDS words per cycle
// through external S-box lanes, with start/done handshake and abort.
module aes_encipher_multilane
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_WORDS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      keylen,
  input  logic [127:0]              block,
  output logic [3:0]                round,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_WORDS-1:0]  sboxw,
  input  logic [32*SBOX_WORDS-1:0]  new_sboxw,
  output logic [127:0]              new_block,
  output logic                      ready,
  output logic                      done
);

  localparam int unsigned S           = 4 / SBOX_WORDS;
  localparam logic [1:0]  SWORD_LAST  = 2'(S - 1);
  localparam logic [1:0]  LANE_STRIDE = 2'(SBOX_WORDS);

  if (SBOX_WORDS != 1 && SBOX_WORDS != 2 && SBOX_WORDS != 4) begin : g_bad_sbox_words
    $error("aes_encipher_multilane: SBOX_WORDS must be 1, 2 or 4");
  end

  aes_enc_state_e  fsm_q, fsm_d;
  logic [3:0][31:0] block_q, block_d;
  logic [3:0]       nr_q, nr_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       sword_q, sword_d;
  logic             done_q, done_d;

  logic [SBOX_WORDS-1:0][31:0] lanes_out, lanes_in;
  logic [127:0] init_blk, main_blk, final_blk;
  logic [1:0]   widx;

  aes_enc_round_datapath u_datapath (
    .state       (block_q),
    .round_key   (round_key),
    .init_block  (init_blk),
    .main_block  (main_blk),
    .final_block (final_blk)
  );

  assign lanes_in  = new_sboxw;
  assign sboxw     = lanes_out;
  assign new_block = block_q;
  assign round     = round_q;
  assign ready     = (fsm_q == IDLE);
  assign done      = done_q;

  always_comb begin
    fsm_d     = fsm_q;
    block_d   = block_q;
    nr_d      = nr_q;
    round_d   = round_q;
    sword_d   = sword_q;
    done_d    = 1'b0;
    lanes_out = '0;
    widx      = '0;

    case (fsm_q)
      IDLE: begin
        if (start && !abort) begin
          block_d = block;
          nr_d    = (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
          round_d = '0;
          sword_d = '0;
          fsm_d   = INIT;
        end
      end
      INIT: begin
        block_d = init_blk;
        round_d = 4'd1;
        sword_d = '0;
        fsm_d   = SBOX;
      end
      SBOX: begin
        // State word k (w0 = MSB) is packed element 3-k; lane 0 is the top lane.
        for (int unsigned j = 0; j < SBOX_WORDS; j++) begin
          widx = sword_q * LANE_STRIDE + 2'(j);
          lanes_out[SBOX_WORDS-1-j] = block_q[2'd3 - widx];
          block_d[2'd3 - widx]      = lanes_in[SBOX_WORDS-1-j];
        end
        if (sword_q == SWORD_LAST) begin
          sword_d = '0;
          fsm_d   = MAIN;
        end else begin
          sword_d = sword_q + 2'd1;
        end
      end
      MAIN: begin
        if (round_q < nr_q) begin
          block_d = main_blk;
          round_d = round_q + 4'd1;
          fsm_d   = SBOX;
        end else begin
          block_d = final_blk;
          done_d  = 1'b1;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (abort && fsm_q != IDLE) begin
      fsm_d   = IDLE;
      block_d = '0;
      round_d = '0;
      sword_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      block_q <= '0;
      nr_q    <= AES128_ROUNDS;
      round_q <= '0;
      sword_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      block_q <= block_d;
      nr_q    <= nr_d;
      round_q <= round_d;
      sword_q <= sword_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_encipher_multilane.sv
// Bench for aes_encipher_multilane: three instances (1, 2 and 4 S-box lanes)
// checked against a byte-level AES reference model and FIPS-197 vectors.
module tb_aes_encipher_multilane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic         reset_v  [3];
  logic         start_v  [3];
  logic         abort_v  [3];
  logic         keylen_v [3];
  logic [127:0] block_v  [3];
  logic [3:0]   round_v  [3];
  logic [127:0] nblock_v [3];
  logic         ready_v  [3];
  logic         done_v   [3];
  logic         sbidle_v [3];

  logic [127:0] rk_tab [3][16];
  logic [7:0]   sbox_t [256];

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int unsigned SW = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [32*SW-1:0] sboxw, new_sboxw;
    logic [127:0]     rk, nb;
    logic [3:0]       rnd;
    logic             rdy, dn;

    assign rk = rk_tab[g][rnd];
    for (genvar k = 0; k < 4 * SW; k++) begin : g_byte
      assign new_sboxw[8*k +: 8] = sbox_t[sboxw[8*k +: 8]];
    end

    aes_encipher_multilane #(.SBOX_WORDS(SW)) dut (
      .clk       (clk),
      .reset     (reset_v[g]),
      .start     (start_v[g]),
      .abort     (abort_v[g]),
      .keylen    (keylen_v[g]),
      .block     (block_v[g]),
      .round     (rnd),
      .round_key (rk),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw),
      .new_block (nb),
      .ready     (rdy),
      .done      (dn)
    );

    assign round_v[g]  = rnd;
    assign nblock_v[g] = nb;
    assign ready_v[g]  = rdy;
    assign done_v[g]   = dn;
    assign sbidle_v[g] = (sboxw == '0);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [256];
    logic [7:0] lg [256];
    logic [7:0] p, inv;
    p = 8'h01;
    for (int unsigned i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = 8'(i);
      p = gmul(p, 8'h03);
    end
    for (int unsigned x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic expand(input int g, input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int unsigned nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    for (int unsigned i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int unsigned i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int unsigned r = 0; r < 16; r++)
      rk_tab[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Byte array s[4*col + row]; byte 0 is the MSB of the block.
  function automatic logic [127:0] ref_encrypt(input int g, input logic kl, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, res;
    int unsigned  nr;
    nr = kl ? 14 : 10;
    k  = rk_tab[g][0];
    for (int unsigned i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int unsigned rnd = 1; rnd <= nr; rnd++) begin
      for (int unsigned i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int unsigned c = 0; c < 4; c++)
        for (int unsigned r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
      for (int unsigned c = 0; c < 4; c++)
        for (int unsigned r = 0; r < 4; r++)
          s[4*c + r] = (rnd < nr) ? (gmul(t[4*c + r], 8'h02) ^ gmul(t[4*c + (r+1)%4], 8'h03) ^
                                     t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4])
                                  : t[4*c + r];
      k = rk_tab[g][rnd];
      for (int unsigned i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
    end
    for (int unsigned i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int unsigned i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_op(input int g, input logic [255:0] key, input logic kl,
                          input logic [127:0] pt, output logic [127:0] exp_ct);
    expand(g, key, kl);
    exp_ct      = ref_encrypt(g, kl, pt);
    keylen_v[g] = kl;
    block_v[g]  = pt;
    start_v[g]  = 1'b1;
  endtask

  task automatic wait_edges(input int g, input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      @(negedge clk);
      start_v[g] = 1'b0;
    end
  endtask

  // m counts edges after the start-accept edge; done is due at m == lat.
  task automatic run_op(input int g, input logic kl, input logic [127:0] exp_ct,
                        input bit disturb, input bit chain, input string tag);
    int unsigned sw, s, nr, lat, m;
    sw = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    s  = 4 / sw;
    nr = kl ? 14 : 10;
    lat = 1 + nr * (s + 1);
    m = 0;
    while (1) begin
      @(negedge clk);
      if (m == 0) start_v[g] = 1'b0;
      if (disturb) begin
        if (m == 3) begin
          keylen_v[g] = ~keylen_v[g];
          block_v[g]  = ~block_v[g];
        end
        if (m == 10) start_v[g] = 1'b1;
        if (m == 11) start_v[g] = 1'b0;
      end
      if (done_v[g] === 1'b1 || m >= lat + 20) break;
      chk({tag, " round"}, 128'(round_v[g]), 128'((m + s) / (s + 1)));
      if (m % (s + 1) == 0) chk({tag, " sboxw idle"}, 128'(sbidle_v[g]), 128'd1);
      m++;
    end
    chk({tag, " latency"}, 128'(m), 128'(lat));
    chk({tag, " ciphertext"}, nblock_v[g], exp_ct);
    chk({tag, " ready with done"}, 128'(ready_v[g]), 128'd1);
    if (!chain) begin
      @(negedge clk);
      chk({tag, " done one cycle"}, 128'(done_v[g]), 128'd0);
      chk({tag, " result held"}, nblock_v[g], exp_ct);
    end
  endtask

  task automatic chk_reset_state(input int g, input string tag);
    chk({tag, " ready"}, 128'(ready_v[g]), 128'd1);
    chk({tag, " done"}, 128'(done_v[g]), 128'd0);
    chk({tag, " new_block"}, nblock_v[g], 128'd0);
    chk({tag, " round"}, 128'(round_v[g]), 128'd0);
    chk({tag, " sboxw"}, 128'(sbidle_v[g]), 128'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] ct, ct2;
    logic [255:0] key;
    logic         kl;
    int           dones;

    build_sbox();
    for (int unsigned g = 0; g < 3; g++) begin
      reset_v[g] = 1'b1; start_v[g] = 1'b0; abort_v[g] = 1'b0;
      keylen_v[g] = 1'b0; block_v[g] = '0;
      for (int unsigned r = 0; r < 16; r++) rk_tab[g][r] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_reset_state(g, $sformatf("reset lane%0d", g));
    for (int unsigned g = 0; g < 3; g++) reset_v[g] = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1, AES-128, one lane.
    start_op(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
             128'h00112233445566778899aabbccddeeff, ct);
    run_op(0, 1'b0, ct, 1'b0, 1'b0, "c1");
    chk("c1 fips", nblock_v[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // FIPS-197 C.3, AES-256, four lanes.
    start_op(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
             128'h00112233445566778899aabbccddeeff, ct);
    run_op(2, 1'b1, ct, 1'b0, 1'b0, "c3");
    chk("c3 fips", nblock_v[2], 128'h8ea2b7ca516745bfeafc49904b496089);

    // FIPS-197 appendix B, AES-128, two lanes.
    start_op(1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
             128'h3243f6a8885a308d313198a2e0370734, ct);
    run_op(1, 1'b0, ct, 1'b0, 1'b0, "appb");
    chk("appb fips", nblock_v[1], 128'h3925841d02dc09fbdc118597196a0b32);

    // Input changes and a stray start mid-run, then a back-to-back start in the done cycle.
    start_op(0, {rand256()}, 1'b0, 128'(rand256()), ct);
    run_op(0, 1'b0, ct, 1'b1, 1'b1, "disturb");
    start_op(0, rand256(), 1'b1, 128'(rand256()), ct2);
    run_op(0, 1'b1, ct2, 1'b0, 1'b0, "back2back");

    // Random operations across all lane widths and key lengths.
    for (int i = 0; i < 6; i++) begin
      kl = 1'($urandom_range(0, 1));
      key = rand256();
      start_op(i % 3, key, kl, 128'(rand256()), ct);
      run_op(i % 3, kl, ct, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    // Abort sampled at edge 20 of an AES-256 run.
    start_op(2, rand256(), 1'b1, 128'(rand256()), ct);
    wait_edges(2, 20);
    abort_v[2] = 1'b1;
    @(negedge clk);
    abort_v[2] = 1'b0;
    chk("abort ready", 128'(ready_v[2]), 128'd1);
    chk("abort new_block", nblock_v[2], 128'd0);
    chk("abort done", 128'(done_v[2]), 128'd0);
    chk("abort round", 128'(round_v[2]), 128'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_v[2] !== 1'b0) dones++;
    end
    chk("abort no done", 128'(dones), 128'd0);

    // Abort together with start in IDLE: start dropped, result held.
    start_op(2, rand256(), 1'b0, 128'(rand256()), ct);
    run_op(2, 1'b0, ct, 1'b0, 1'b0, "pre-idle-abort");
    block_v[2] = ~block_v[2];
    start_v[2] = 1'b1;
    abort_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    abort_v[2] = 1'b0;
    chk("idle abort ready", 128'(ready_v[2]), 128'd1);
    chk("idle abort held", nblock_v[2], ct);
    @(negedge clk);
    chk("idle abort still idle", 128'(ready_v[2]), 128'd1);

    // Abort during the final MAIN cycle suppresses done.
    start_op(0, rand256(), 1'b0, 128'(rand256()), ct);
    wait_edges(0, 51);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("final abort done", 128'(done_v[0]), 128'd0);
    chk("final abort ready", 128'(ready_v[0]), 128'd1);
    chk("final abort new_block", nblock_v[0], 128'd0);

    // Reset during SBOX, then a normal operation.
    start_op(1, rand256(), 1'b1, 128'(rand256()), ct);
    wait_edges(1, 2);
    reset_v[1] = 1'b1;
    @(negedge clk);
    reset_v[1] = 1'b0;
    chk_reset_state(1, "midrun reset");
    start_op(1, rand256(), 1'b1, 128'(rand256()), ct);
    run_op(1, 1'b1, ct, 1'b0, 1'b0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
